// File: rtl/mmio_host_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | mmio_host_pkg: register map and FSM state encoding for the MMIO sequencer  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mmio_host_pkg;

  localparam logic [15:0] REG_GO          = 16'h0050;
  localparam logic [15:0] REG_RD_ADDR     = 16'h0052;
  localparam logic [15:0] REG_WR_ADDR     = 16'h0054;
  localparam logic [15:0] REG_NUM_SAMPLES = 16'h0056;
  localparam logic [15:0] REG_COLLECT     = 16'h0058;
  localparam logic [15:0] REG_DONE        = 16'h0060;
  localparam logic [15:0] REG_RSA_GO      = 16'h0072;

  // Write-phase slot indices; slot 4 is skipped when the RSA trigger is off.
  localparam logic [2:0] WIDX_COLLECT = 3'd3;
  localparam logic [2:0] WIDX_RSA     = 3'd4;
  localparam logic [2:0] WIDX_GO      = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    GAP     = 3'd4,
    FINISH  = 3'd5,
    ERROR   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mmio_host_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | mmio_host_sequencer_if: MMIO write/read bus between initiator and responder|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mmio_host_sequencer_if;
  logic        mmio_wr_en;
  logic [15:0] mmio_wr_addr;
  logic [63:0] mmio_wr_data;
  logic        mmio_rd_en;
  logic [15:0] mmio_rd_addr;
  logic [63:0] mmio_rd_data;

  modport master (
    output mmio_wr_en, mmio_wr_addr, mmio_wr_data, mmio_rd_en, mmio_rd_addr,
    input  mmio_rd_data
  );

  modport slave (
    input  mmio_wr_en, mmio_wr_addr, mmio_wr_data, mmio_rd_en, mmio_rd_addr,
    output mmio_rd_data
  );
endinterface

`default_nettype wire

// File: rtl/mmio_host_sequencer_poll_timer.sv
// +----------------------------------------------------------------------------+
// | poll_timer: loadable down-counter; expired_o is high while the count is 0  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module poll_timer #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/mmio_host_sequencer.sv
// +----------------------------------------------------------------------------+
// | mmio_host_sequencer: writes AFU config registers, fires go, polls done     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mmio_host_sequencer
  import mmio_host_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int POLL_GAP   = 16,
  parameter int MAX_POLLS  = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  start,
  input  wire logic                  rsa_en,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  wire logic [SIZE_WIDTH-1:0] num_samples_in,
  input  wire logic [SIZE_WIDTH-1:0] collect_cycles_in,
  mmio_host_sequencer_if.master      bus,
  output logic                       busy,
  output logic                       done_out,
  output logic                       timeout_err,
  output logic [15:0]                poll_count
);

  if (ADDR_WIDTH > 64 || SIZE_WIDTH > 64 || RD_LATENCY < 1 || RD_LATENCY > 4 ||
      POLL_GAP < 1) begin : g_bad_params
    $error("mmio_host_sequencer: illegal parameter combination");
  end

  state_t                state_q;
  logic [2:0]            wr_idx_q;
  logic                  rsa_q;
  logic [ADDR_WIDTH-1:0] op_rd_addr_q;
  logic [ADDR_WIDTH-1:0] op_wr_addr_q;
  logic [SIZE_WIDTH-1:0] op_num_q;
  logic [SIZE_WIDTH-1:0] op_coll_q;

  logic                  mmio_wr_en_q;
  logic [15:0]           mmio_wr_addr_q;
  logic [63:0]           mmio_wr_data_q;
  logic                  mmio_rd_en_q;
  logic [15:0]           mmio_rd_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;
  logic [15:0]           poll_count_q;

  logic [2:0]            wr_idx_d;
  logic [15:0]           wr_addr_d;
  logic [63:0]           wr_data_d;
  logic                  tmr_load;
  logic [31:0]           tmr_val;
  logic                  tmr_expired;
  logic                  poll_limit_hit;

  always_comb begin
    wr_idx_d  = wr_idx_q + 3'd1;
    wr_addr_d = REG_GO;
    wr_data_d = 64'd1;
    unique case (wr_idx_q)
      3'd0: begin
        wr_addr_d = REG_RD_ADDR;
        wr_data_d = 64'(op_rd_addr_q);
      end
      3'd1: begin
        wr_addr_d = REG_WR_ADDR;
        wr_data_d = 64'(op_wr_addr_q);
      end
      3'd2: begin
        wr_addr_d = REG_NUM_SAMPLES;
        wr_data_d = 64'(op_num_q);
      end
      WIDX_COLLECT: begin
        wr_addr_d = REG_COLLECT;
        wr_data_d = 64'(op_coll_q);
        wr_idx_d  = rsa_q ? WIDX_RSA : WIDX_GO;
      end
      WIDX_RSA: begin
        wr_addr_d = REG_RSA_GO;
      end
      default: begin
        wr_idx_d = WIDX_GO;
      end
    endcase
  end

  // One timer serves both the read-latency wait and the inter-poll gap.
  always_comb begin
    tmr_load = (state_q == RD_REQ) || ((state_q == RD_WAIT) && tmr_expired);
    tmr_val  = (state_q == RD_REQ) ? 32'(RD_LATENCY - 1) : 32'(POLL_GAP - 1);
  end

  assign poll_limit_hit = (MAX_POLLS != 0) && (32'(poll_count_q) == 32'(MAX_POLLS));

  poll_timer #(
    .WIDTH (32)
  ) u_poll_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_idx_q       <= 3'd0;
      rsa_q          <= 1'b0;
      op_rd_addr_q   <= '0;
      op_wr_addr_q   <= '0;
      op_num_q       <= '0;
      op_coll_q      <= '0;
      mmio_wr_en_q   <= 1'b0;
      mmio_wr_addr_q <= 16'd0;
      mmio_wr_data_q <= 64'd0;
      mmio_rd_en_q   <= 1'b0;
      mmio_rd_addr_q <= 16'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      poll_count_q   <= 16'd0;
    end else begin
      mmio_wr_en_q   <= 1'b0;
      mmio_wr_addr_q <= 16'd0;
      mmio_wr_data_q <= 64'd0;
      mmio_rd_en_q   <= 1'b0;
      mmio_rd_addr_q <= 16'd0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_rd_addr_q <= rd_addr_in;
            op_wr_addr_q <= wr_addr_in;
            op_num_q     <= num_samples_in;
            op_coll_q    <= collect_cycles_in;
            rsa_q        <= rsa_en;
            poll_count_q <= 16'd0;
            wr_idx_q     <= 3'd0;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          busy_q         <= 1'b1;
          mmio_wr_en_q   <= 1'b1;
          mmio_wr_addr_q <= wr_addr_d;
          mmio_wr_data_q <= wr_data_d;
          wr_idx_q       <= wr_idx_d;
          if (wr_idx_q == WIDX_GO) begin
            state_q <= RD_REQ;
          end
        end
        RD_REQ: begin
          mmio_rd_en_q   <= 1'b1;
          mmio_rd_addr_q <= REG_DONE;
          if (poll_count_q != 16'hFFFF) begin
            poll_count_q <= poll_count_q + 16'd1;
          end
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (tmr_expired) begin
            if (bus.mmio_rd_data[0]) begin
              state_q <= FINISH;
            end else if (poll_limit_hit) begin
              state_q <= ERROR;
            end else begin
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (tmr_expired) begin
            state_q <= RD_REQ;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ERROR: begin
          timeout_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mmio_wr_en   = mmio_wr_en_q;
  assign bus.mmio_wr_addr = mmio_wr_addr_q;
  assign bus.mmio_wr_data = mmio_wr_data_q;
  assign bus.mmio_rd_en   = mmio_rd_en_q;
  assign bus.mmio_rd_addr = mmio_rd_addr_q;
  assign busy             = busy_q;
  assign done_out         = done_q;
  assign timeout_err      = timeout_q;
  assign poll_count       = poll_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_host_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_mmio_host_sequencer: scoreboard bench with a latency-modelled responder |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_host_sequencer;
  import mmio_host_pkg::*;

  localparam int LAT  = 3;
  localparam int GAPC = 4;
  localparam int MAXP = 4;
  localparam int PER  = 1 + LAT + GAPC;

  typedef struct {
    int          at;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    int at;
    int kind;   // 0 = done_out, 1 = timeout_err
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rsa_en = 1'b0;
  logic [63:0] rd_addr_in = 64'd0;
  logic [63:0] wr_addr_in = 64'd0;
  logic [31:0] num_samples_in = 32'd0;
  logic [31:0] collect_cycles_in = 32'd0;
  logic        busy;
  logic        done_out;
  logic        timeout_err;
  logic [15:0] poll_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int poll_num = 0;
  int done_poll = 0;
  int rsp_off = 0;
  logic rsp_dv;

  wr_t  exp_wr[$];
  int   exp_rd[$];
  evt_t exp_evt[$];

  mmio_host_sequencer_if bus ();

  mmio_host_sequencer #(
    .ADDR_WIDTH (64),
    .SIZE_WIDTH (32),
    .RD_LATENCY (LAT),
    .POLL_GAP   (GAPC),
    .MAX_POLLS  (MAXP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .rsa_en            (rsa_en),
    .rd_addr_in        (rd_addr_in),
    .wr_addr_in        (wr_addr_in),
    .num_samples_in    (num_samples_in),
    .collect_cycles_in (collect_cycles_in),
    .bus               (bus),
    .busy              (busy),
    .done_out          (done_out),
    .timeout_err       (timeout_err),
    .poll_count        (poll_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Responder: done bit is valid only on the cycle sampled LAT edges after the
  // read strobe; earlier cycles carry the inverted bit as a decoy.
  always @(negedge clk) begin
    if (bus.mmio_rd_en === 1'b1) begin
      poll_num++;
      rsp_off = 1;
    end else if (rsp_off != 0 && rsp_off < LAT) begin
      rsp_off++;
    end else begin
      rsp_off = 0;
    end
    rsp_dv = (done_poll != 0) && (poll_num >= done_poll);
    if (rsp_off == LAT && rsp_off != 0)
      bus.mmio_rd_data = {63'h0, rsp_dv};
    else if (rsp_off != 0)
      bus.mmio_rd_data = {32'hA5A5_0000, 31'h0, ~rsp_dv};
    else
      bus.mmio_rd_data = 64'h0;
  end

  task automatic monitor();
    wr_t  w;
    int   r;
    evt_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (bus.mmio_wr_en === 1'b1 && bus.mmio_rd_en === 1'b1) begin
        errors++;
        $display("FAIL strobe_excl edge %0d: wr_en=1 rd_en=1, required at most one", cyc);
      end
      checks++;
      if ((bus.mmio_wr_en !== 1'b1 && {bus.mmio_wr_addr, bus.mmio_wr_data} !== 80'h0) ||
          (bus.mmio_rd_en !== 1'b1 && bus.mmio_rd_addr !== 16'h0)) begin
        errors++;
        $display("FAIL strobe_low edge %0d: wr_addr=%h wr_data=%h rd_addr=%h, required 0",
                 cyc, bus.mmio_wr_addr, bus.mmio_wr_data, bus.mmio_rd_addr);
      end
      if (bus.mmio_wr_en === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write edge %0d: addr=%h data=%h, required none",
                   cyc, bus.mmio_wr_addr, bus.mmio_wr_data);
        end else begin
          w = exp_wr.pop_front();
          if (cyc != w.at || bus.mmio_wr_addr !== w.addr || bus.mmio_wr_data !== w.data) begin
            errors++;
            $display("FAIL write edge=%0d addr=%h data=%h, required edge=%0d addr=%h data=%h",
                     cyc, bus.mmio_wr_addr, bus.mmio_wr_data, w.at, w.addr, w.data);
          end
        end
      end
      if (bus.mmio_rd_en === 1'b1) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read edge %0d: addr=%h, required none", cyc, bus.mmio_rd_addr);
        end else begin
          r = exp_rd.pop_front();
          if (cyc != r || bus.mmio_rd_addr !== REG_DONE) begin
            errors++;
            $display("FAIL read edge=%0d addr=%h, required edge=%0d addr=%h",
                     cyc, bus.mmio_rd_addr, r, REG_DONE);
          end
        end
      end
      if (done_out === 1'b1 || timeout_err === 1'b1) begin
        checks++;
        if (exp_evt.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse edge %0d: done=%b timeout=%b, required none",
                   cyc, done_out, timeout_err);
        end else begin
          e = exp_evt.pop_front();
          if (cyc != e.at || done_out !== (e.kind == 0) || timeout_err !== (e.kind == 1) ||
              busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse edge=%0d done=%b timeout=%b busy=%b, required edge=%0d done=%b timeout=%b busy=0",
                     cyc, done_out, timeout_err, busy, e.at, e.kind == 0, e.kind == 1);
          end
        end
      end
    end
  endtask

  // Called at a negedge; drives start for the next edge and pushes expectations.
  task automatic launch(input logic [63:0] ra, input logic [63:0] wa, input logic [31:0] ns,
                        input logic [31:0] cc, input bit rsa, input int dpoll, output int s);
    int   r0;
    int   np;
    evt_t e;
    rd_addr_in        = ra;
    wr_addr_in        = wa;
    num_samples_in    = ns;
    collect_cycles_in = cc;
    rsa_en            = rsa;
    start             = 1'b1;
    s = cyc + 1;
    exp_wr.push_back('{s + 1, REG_RD_ADDR, ra});
    exp_wr.push_back('{s + 2, REG_WR_ADDR, wa});
    exp_wr.push_back('{s + 3, REG_NUM_SAMPLES, {32'h0, ns}});
    exp_wr.push_back('{s + 4, REG_COLLECT, {32'h0, cc}});
    if (rsa) exp_wr.push_back('{s + 5, REG_RSA_GO, 64'd1});
    exp_wr.push_back('{s + (rsa ? 6 : 5), REG_GO, 64'd1});
    r0 = s + (rsa ? 7 : 6);
    np = (dpoll != 0) ? dpoll : MAXP;
    for (int k = 0; k < np; k++) exp_rd.push_back(r0 + k * PER);
    e.at   = r0 + (np - 1) * PER + LAT + 1;
    e.kind = (dpoll != 0) ? 0 : 1;
    exp_evt.push_back(e);
    done_poll = (dpoll != 0) ? poll_num + dpoll : 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_evt.size() == 0) break;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done_out, timeout_err, poll_count, bus.mmio_wr_en, bus.mmio_rd_en,
         bus.mmio_wr_addr, bus.mmio_wr_data, bus.mmio_rd_addr} !== 118'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b to=%b pc=%h wr_en=%b rd_en=%b, required all 0",
               busy, done_out, timeout_err, poll_count, bus.mmio_wr_en, bus.mmio_rd_en);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int s;
    @(negedge clk);
    launch(64'h1000, 64'h2000, 32'd8, 32'd100, 1'b0, 3, s);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_edge0: busy=%b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_edge1: busy=%b, required 1", busy);
    end
    wait_drain(200);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_evt.size() != 0 || poll_count !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: pending=%0d poll_count=%0d busy=%b, required pending=0 poll_count=3 busy=0",
               exp_wr.size() + exp_rd.size() + exp_evt.size(), poll_count, busy);
    end
  endtask

  task automatic test_rsa();
    int s;
    @(negedge clk);
    launch(64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
           1'b1, 2, s);
    wait_drain(200);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_evt.size() != 0 || poll_count !== 16'd2) begin
      errors++;
      $display("FAIL rsa_end: pending=%0d poll_count=%0d, required pending=0 poll_count=2",
               exp_wr.size() + exp_rd.size() + exp_evt.size(), poll_count);
    end
  endtask

  task automatic test_timeout();
    int s;
    @(negedge clk);
    launch(64'h3000, 64'h4000, 32'd16, 32'd7, 1'b0, 0, s);
    wait_drain(200);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_evt.size() != 0 || poll_count !== 16'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_end: pending=%0d poll_count=%0d busy=%b, required pending=0 poll_count=4 busy=0",
               exp_wr.size() + exp_rd.size() + exp_evt.size(), poll_count, busy);
    end
  endtask

  task automatic test_ignored_start();
    int s;
    @(negedge clk);
    launch(64'h5555, 64'h6666, 32'd3, 32'd9, 1'b0, 1, s);
    @(negedge clk);
    start             = 1'b1;
    rsa_en            = 1'b1;
    rd_addr_in        = 64'hBAD0;
    wr_addr_in        = 64'hBAD1;
    num_samples_in    = 32'hBAD2;
    collect_cycles_in = 32'hBAD3;
    @(negedge clk);
    start = 1'b0;
    wait_drain(200);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_evt.size() != 0 || poll_count !== 16'd1) begin
      errors++;
      $display("FAIL ignored_start_end: pending=%0d poll_count=%0d, required pending=0 poll_count=1",
               exp_wr.size() + exp_rd.size() + exp_evt.size(), poll_count);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    int s2;
    int d;
    @(negedge clk);
    launch(64'h7000, 64'h7100, 32'd1, 32'd2, 1'b0, 1, s);
    d = s + 6 + LAT + 1;
    for (int i = 0; i < 100 && cyc < d - 1; i++) @(negedge clk);
    // Sampled on the pulse edge while FINISH returns to IDLE: must be ignored.
    start             = 1'b1;
    rd_addr_in        = 64'hDEAD;
    wr_addr_in        = 64'hDEAD;
    num_samples_in    = 32'hDEAD;
    collect_cycles_in = 32'hDEAD;
    @(negedge clk);
    launch(64'h9000, 64'h9100, 32'd5, 32'd6, 1'b1, 2, s2);
    checks++;
    if (s2 != d + 1) begin
      errors++;
      $display("FAIL b2b_alignment: second start edge=%0d, required %0d", s2, d + 1);
    end
    wait_drain(300);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_evt.size() != 0 || poll_count !== 16'd2) begin
      errors++;
      $display("FAIL b2b_end: pending=%0d poll_count=%0d, required pending=0 poll_count=2",
               exp_wr.size() + exp_rd.size() + exp_evt.size(), poll_count);
    end
  endtask

  task automatic test_midrun_reset();
    int s;
    @(negedge clk);
    launch(64'hA000, 64'hB000, 32'd4, 32'd5, 1'b0, 1, s);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    exp_wr.delete();
    exp_rd.delete();
    exp_evt.delete();
    @(negedge clk);
    checks++;
    if ({busy, done_out, timeout_err, poll_count, bus.mmio_wr_en, bus.mmio_rd_en,
         bus.mmio_wr_addr, bus.mmio_wr_data, bus.mmio_rd_addr} !== 118'h0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: busy=%b wr_en=%b rd_en=%b pc=%h, required all 0",
               busy, bus.mmio_wr_en, bus.mmio_rd_en, poll_count);
    end
    rst = 1'b1;
    repeat (40) @(negedge clk);
    launch(64'hC000, 64'hD000, 32'd10, 32'd11, 1'b0, 2, s);
    wait_drain(200);
    checks++;
    if (exp_wr.size() + exp_rd.size() + exp_evt.size() != 0 || poll_count !== 16'd2) begin
      errors++;
      $display("FAIL midrun_rerun_end: pending=%0d poll_count=%0d, required pending=0 poll_count=2",
               exp_wr.size() + exp_rd.size() + exp_evt.size(), poll_count);
    end
  endtask

  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_basic();
    test_rsa();
    test_timeout();
    test_ignored_start();
    test_back_to_back();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at edge %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mmio_host_sequencer.md
# mmio_host_sequencer

Initiator-side MMIO driver for the ring-oscillator AFU register map. On a single `start` pulse it writes the DMA/sampling configuration registers, optionally triggers the RSA workload, and fires `go`. It then polls the `done` register until completion or timeout. It sits in front of the memory-map responder, either in a self-test wrapper or in an embedded controller that replaces host software.

## Interface
- `ADDR_WIDTH`, 64: width of `rd_addr_in`/`wr_addr_in`.
- `SIZE_WIDTH`, 32: width of `num_samples_in`/`collect_cycles_in`.
- `RD_LATENCY`, 1: cycles from `mmio_rd_en` to valid `mmio_rd_data`; legal range 1..4.
- `POLL_GAP`, 16: idle cycles between consecutive done polls; legal range ≥1.
- `MAX_POLLS`, 0: poll attempts before timeout; 0 disables the timeout.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle request; accepted only in IDLE.
- `rsa_en`, in, 1: if high at `start`, also write `rsa_go` (0x0072).
- `rd_addr_in`, in, ADDR_WIDTH: DMA read address.
- `wr_addr_in`, in, ADDR_WIDTH: DMA write address.
- `num_samples_in`, in, SIZE_WIDTH: cache lines to transfer.
- `collect_cycles_in`, in, SIZE_WIDTH: RO collection window.
- `mmio_wr_en`, out, 1: write strobe, one cycle per write.
- `mmio_wr_addr`, out, 16: write register address.
- `mmio_wr_data`, out, 64: write data, zero-extended.
- `mmio_rd_en`, out, 1: read strobe.
- `mmio_rd_addr`, out, 16: read register address.
- `mmio_rd_data`, in, 64: responder read data.
- `busy`, out, 1: high from the cycle after `start` acceptance until FINISH or ERROR.
- `done_out`, out, 1: one-cycle pulse on observed completion.
- `timeout_err`, out, 1: one-cycle pulse when the poll limit is exhausted.
- `poll_count`, out, 16: polls issued in the current or last run; saturates at 0xFFFF.

## Operation
- **States:** IDLE, WRITE, RD_REQ, RD_WAIT, GAP, FINISH, ERROR.
- **IDLE:**
  - `start` latches all `*_in` operands and `rsa_en`, clears `poll_count`, and moves to WRITE with write index 0.
  - Operand changes after acceptance have no effect.
- **WRITE:** issues one write per cycle in fixed order:
  - 0x0052 rd_addr
  - 0x0054 wr_addr
  - 0x0056 num_samples
  - 0x0058 collect_cycles
  - 0x0072 data 1, only when `rsa_en` was latched
  - 0x0050 data 1 (go), always last
  - After the go write, the next state is RD_REQ.
- **RD_REQ:** asserts `mmio_rd_en` for exactly one cycle with `mmio_rd_addr`=0x0060 and increments `poll_count`, then moves to RD_WAIT.
- **RD_WAIT:** waits RD_LATENCY cycles, then samples `mmio_rd_data[0]`.
  - Bit set: go to FINISH.
  - Bit clear and `poll_count`==MAX_POLLS with MAX_POLLS≠0: go to ERROR.
  - Otherwise: go to GAP.
- **GAP:** counts POLL_GAP cycles, then returns to RD_REQ.
- **FINISH / ERROR:** pulse `done_out` or `timeout_err` for one cycle and return to IDLE on the next cycle.
- **Mutual exclusion:** `mmio_wr_en` and `mmio_rd_en` are never high in the same cycle.
- **Strobe-low outputs:** when a strobe is low, its address and data outputs are 0.
- **Ignored `start`:** `start` outside IDLE is ignored. `start` in the same cycle that FINISH or ERROR returns to IDLE is also ignored.

## Timing
- **Reset (`rst`=0 at a clock edge):**
  - All outputs go to 0 and the state goes to IDLE.
  - Reset applies mid-sequence with no completion pulse.
  - An interrupted sequence is not resumed.
- **Cycle numbering:** `start` is sampled high at edge 0.
- **Write phase:**
  - First write is visible from edge 1, last write (go) at edge 5, or edge 6 with `rsa_en`.
  - `busy` is high from edge 1.
- **First poll:** `mmio_rd_en` is high at edge 6 (7 with `rsa_en`). `mmio_rd_data` is sampled RD_LATENCY edges later.
- **Poll period:** 1 + RD_LATENCY + POLL_GAP cycles.
- **Completion:**
  - `done_out`/`timeout_err` rise one edge after the deciding sample.
  - `busy` falls in the same cycle the pulse is high.
  - IDLE is re-entered, and can accept `start`, one cycle after the pulse.
- **Width rules:**
  - `mmio_wr_data` zero-extends operands narrower than 64 bits.
  - Operands wider than 64 bits are illegal; elaboration fails.

## Structure
- **Package `mmio_host_pkg`:**
  - Register address localparams: REG_GO 0x0050, REG_RD_ADDR 0x0052, REG_WR_ADDR 0x0054, REG_NUM_SAMPLES 0x0056, REG_COLLECT 0x0058, REG_DONE 0x0060, REG_RSA_GO 0x0072.
  - `state_t` enum.
- **Sub-module:** one natural sub-module, `poll_timer`: a loadable down-counter with a `expired` output, shared by RD_WAIT and GAP.

## Test plan
- **Basic run:** `start` with rd=0x1000, wr=0x2000, num=8, coll=100, `rsa_en`=0; responder model raises done on the 3rd poll → five writes in order on edges 1–5, `poll_count`=3, `done_out` pulse exactly once, `busy` low afterward.
- **RSA path:** same run with `rsa_en`=1 → a 0x0072 write with data 1 appears between 0x0058 and 0x0050; first `mmio_rd_en` at edge 7.
- **Timeout:** MAX_POLLS=4, done never set → exactly 4 reads to 0x0060 spaced by 1+RD_LATENCY+POLL_GAP cycles, then one `timeout_err` pulse and no `done_out`.
- **Ignored start:** `start` re-pulsed on edge 3 with different operands → ignored; written values match the first operands.
- **Mid-run reset:** `rst`=0 at edge 2 → all outputs 0 at the next edge, no further MMIO traffic; a new `start` runs a full, clean sequence.
- **Read latency:** RD_LATENCY=3 with done returned only on the 3rd cycle after `rd_en` → completion detected; data on earlier cycles is not sampled.
